div_sequencer: RTL
==================

Name: div_sequencer

Overview:
- Multi-cycle sequencer for DIV/DIVU in the execute stage. Radix-2 restoring datapath, one quotient bit per cycle.
- Accepts the decoded divide flag and the signedness flag from the controller, plus both operands from the execute stage.
- Stalls the pipeline while a divide is in progress, then presents a {remainder, quotient} pair for the HI/LO write.
- A flush annuls an in-flight divide.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset (0 = reset).
- start_i  input  1  divE from the controller; held high while the instruction sits in E.
- signed_i  input  1  hassignE; 1 = DIV, 0 = DIVU.
- annul_i  input  1  flushE or exception; aborts the current divide.
- opa_i  input  WIDTH  dividend (rs).
- opb_i  input  WIDTH  divisor (rt).
- stall_o  output  1  freeze F/D/E and bubble M while high.
- busy_o  output  1  state is not IDLE.
- ready_o  output  1  one-cycle pulse; result_o is valid.
- result_o  output  2*WIDTH  {HI = remainder, LO = quotient}.
- div_zero_o  output  1  pulses together with ready_o when the divisor was 0.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, all outputs 0, result_o=0.
- States: IDLE, CALC, ZERO, DONE.
- IDLE:
  - start_i=1 and annul_i=0: latch operands and signed_i; go to CALC if opb_i!=0, else to ZERO.
  - Otherwise stay in IDLE.
- Operand preparation (at the latch): when signed, store |opa| and |opb|. Record neg_q = sign(opa) XOR sign(opb) and neg_r = sign(opa).
- CALC: performs WIDTH iterations, counter 0..WIDTH-1.
  - Each iteration: shift {rem,quo} left by 1, then trial-subtract the divisor from rem.
  - If there is no borrow, keep the difference and set quo[0]=1.
  - At counter=WIDTH-1, go to DONE.
- ZERO: one cycle, then DONE. The result is HI=opa_i as latched (unaltered) and LO=all ones, with div_zero_o asserted in DONE.
- DONE: one cycle.
  - ready_o=1; result_o is updated with the sign-corrected values: quotient negated if neg_q, remainder negated if neg_r.
  - Then go to IDLE. start_i is ignored in DONE, because it still belongs to the completing instruction.
- stall_o = (IDLE & start_i & !annul_i) | CALC | ZERO. It is combinational and drops in DONE.
- Latency: the start cycle counts as cycle 0. ready_o is asserted in cycle WIDTH+1 (33 for the default), or in cycle 2 for a divide by zero.
- result_o holds its value until the next DONE. It is unaffected by annul or by new starts until that point.
- Arithmetic:
  - Two's-complement negation wraps.
  - 0x80000000 / 0xFFFFFFFF signed gives Q=0x80000000, R=0.
  - The remainder always has the sign of the dividend or is 0.
- annul_i=1 in any state other than IDLE: go to IDLE at the next edge. No ready_o, result_o unchanged, stall_o=0 from that cycle on.
- annul_i together with start_i in IDLE: the divide is not started.
- Operand changes after the start cycle have no effect.
- Reset asserted mid-operation: immediate return to reset values.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, when the latched |opb| > |opa| (and opb != 0), go directly to DONE, skipping CALC. The result is Q=0, R=opa (original signed value). ready_o is asserted in cycle 1, and stall_o is high only in cycle 0.
- Undefined: every nonzero divisor takes the full WIDTH+1 latency.

Test Plan:
- DIVU 100/7:
  - Expected result_o={0x00000002, 0x0000000E}.
  - ready_o in cycle 33; stall_o high in cycles 0..32.
  - div_zero_o=0.
- DIV -7/2 (0xFFFFFFF9, 2): Q=0xFFFFFFFD, R=0xFFFFFFFF. DIV 7/-2 gives Q=0xFFFFFFFD, R=1.
- DIV 0x80000000/0xFFFFFFFF: Q=0x80000000, R=0, no hang. DIVU of the same operands gives Q=0, R=0x80000000.
- Divisor 0 (DIVU 5/0): ready_o in cycle 2, div_zero_o=1, result_o={0x00000005, 0xFFFFFFFF}.
- Annul at cycle 10 of DIVU 100/7:
  - Next cycle state=IDLE and stall_o=0; no ready_o follows.
  - result_o keeps its prior value.
  - A fresh start afterwards completes normally.
- Async reset pulse at cycle 5 (no clock edge): outputs drop to 0 immediately. A start held through DONE is not re-accepted; a back-to-back divide starting the cycle after DONE completes correctly.

Source files
------------

// File: rtl/div_sequencer_if.sv
// Handshake and operand/result bundle between the execute stage and the divide sequencer.
interface div_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic                   start_i;
    logic                   signed_i;
    logic                   annul_i;
    logic [WIDTH-1:0]       opa_i;
    logic [WIDTH-1:0]       opb_i;
    logic                   stall_o;
    logic                   busy_o;
    logic                   ready_o;
    logic [2*WIDTH-1:0]     result_o;
    logic                   div_zero_o;

    modport master (
        output start_i, signed_i, annul_i, opa_i, opb_i,
        input  stall_o, busy_o, ready_o, result_o, div_zero_o
    );

    modport slave (
        input  start_i, signed_i, annul_i, opa_i, opb_i,
        output stall_o, busy_o, ready_o, result_o, div_zero_o
    );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer: radix-2 restoring divider, one quotient bit per cycle.
// Optional feature macro: DIV_EARLY_OUT_EN (skip iterations when |divisor| > |dividend|).
module div_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic            clk,
    input logic            rst,
    div_sequencer_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StCalc, StZero, StDone} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 neg_q_q, neg_q_d;
    logic                 neg_r_q, neg_r_d;
    logic                 zero_q, zero_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       shifted, trial;
    logic [2*WIDTH-1:0]   final_res;
    logic                 a_neg, b_neg;

    // Operand magnitudes and one restoring iteration step
    always_comb begin
        a_neg   = bus.signed_i & bus.opa_i[WIDTH-1];
        b_neg   = bus.signed_i & bus.opb_i[WIDTH-1];
        abs_a   = a_neg ? (~bus.opa_i + 1'b1) : bus.opa_i;
        abs_b   = b_neg ? (~bus.opb_i + 1'b1) : bus.opb_i;
        // rem can exceed WIDTH bits after the shift, so the trial uses one extra bit
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        final_res = {(neg_r_q ? (~rem_q + 1'b1) : rem_q),
                     (neg_q_q ? (~quo_q + 1'b1) : quo_q)};
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        zero_d   = zero_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start_i && !bus.annul_i) begin
                    cnt_d = '0;
                    if (bus.opb_i == '0) begin
                        // Divide by zero reports the raw dividend and an all-ones quotient
                        state_d = StZero;
                        rem_d   = bus.opa_i;
                        quo_d   = '1;
                        neg_q_d = 1'b0;
                        neg_r_d = 1'b0;
                        zero_d  = 1'b1;
                    end else begin
                        state_d = StCalc;
                        rem_d   = '0;
                        quo_d   = abs_a;
                        dvs_d   = abs_b;
                        neg_q_d = a_neg ^ b_neg;
                        neg_r_d = a_neg;
                        zero_d  = 1'b0;
`ifdef DIV_EARLY_OUT_EN
                        // Quotient is zero; sign correction restores the original dividend
                        if (abs_b > abs_a) begin
                            state_d = StDone;
                            rem_d   = abs_a;
                            quo_d   = '0;
                        end
`endif
                    end
                end
            end
            StCalc: begin
                if (trial[WIDTH]) begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = StDone;
                end
            end
            StZero: begin
                state_d = StDone;
            end
            StDone: begin
                result_d = final_res;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle && bus.annul_i) begin
            state_d = StIdle;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            zero_q   <= zero_d;
            result_q <= result_d;
        end
    end

    // Outputs; stall is gated by reset so every output is 0 while reset is held
    always_comb begin
        bus.busy_o     = (state_q != StIdle);
        bus.ready_o    = (state_q == StDone);
        bus.div_zero_o = (state_q == StDone) & zero_q;
        bus.result_o   = (state_q == StDone) ? final_res : result_q;
        bus.stall_o    = rst & (((state_q == StIdle) & bus.start_i & ~bus.annul_i) |
                                (state_q == StCalc) | (state_q == StZero));
    end

endmodule
